// File: rtl/ofifo_drain_ctrl.sv
// Drains num_rows rows from the output FIFO into consecutive psum SRAM addresses.
// Reads are spaced by a pending flag because the FIFO registers its read request.
module ofifo_drain_ctrl #(
   parameter int col = 8,
   parameter int bw  = 4,
   parameter int aw  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [aw-1:0]       base_addr,
   input  logic [aw:0]         num_rows,
   input  logic                ofifo_valid,
   input  logic                ofifo_full,
   input  logic [col*bw-1:0]   ofifo_out,
   output logic                ofifo_rd,
   output logic                mem_wr,
   output logic [aw-1:0]       mem_addr,
   output logic [col*bw-1:0]   mem_din,
   output logic                busy,
   output logic                done,
   output logic                overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [aw-1:0]   base_q, base_d;
   logic [aw:0]     num_q, num_d;
   logic [aw:0]     issued_q, issued_d;
   logic [aw:0]     written_q, written_d;
   logic            pend_q, pend_d;
   logic [aw-1:0]   addr_q, addr_d;
   logic            overflow_q, overflow_d;

   logic            start_acc;
   logic            rd_req;
   logic [aw-1:0]   wr_addr;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      issued_d   = issued_q;
      written_d  = written_q;
      pend_d     = pend_q;
      addr_d     = addr_q;

      start_acc  = (state_q == IDLE) && start;
      rd_req     = (state_q == DRAIN) && ofifo_valid && !pend_q && (issued_q < num_q);
      // Address arithmetic is aw bits wide so it wraps naturally at 2^aw.
      wr_addr    = base_q + written_q[aw-1:0];

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d    = base_addr;
               num_d     = num_rows;
               issued_d  = '0;
               written_d = '0;
               pend_d    = 1'b0;
               state_d   = (num_rows == '0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (rd_req) begin
               issued_d = issued_q + 1'b1;
               pend_d   = 1'b1;
            end
            if (pend_q) begin
               written_d = written_q + 1'b1;
               pend_d    = 1'b0;
               addr_d    = wr_addr;
               if (written_q + 1'b1 == num_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A full sample in the same cycle as an accepted start still records the error.
      overflow_d = (start_acc ? 1'b0 : overflow_q) | ofifo_full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         pend_q     <= 1'b0;
         addr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         written_q  <= written_d;
         pend_q     <= pend_d;
         addr_q     <= addr_d;
         overflow_q <= overflow_d;
      end
   end

   assign ofifo_rd = rd_req;
   assign mem_wr   = pend_q;
   assign mem_addr = pend_q ? wr_addr : addr_q;
   assign mem_din  = ofifo_out;
   assign busy     = (state_q == DRAIN) || (state_q == DONE);
   assign done     = (state_q == DONE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Bench for ofifo_drain_ctrl: a queue-based ofifo model feeds the DUT and a
// monitor logs reads, writes and done pulses for comparison with expected results.
module tb_ofifo_drain_ctrl;

   localparam int COL = 8;
   localparam int BW  = 4;
   localparam int AW  = 11;
   localparam int AW1 = AW + 1;
   localparam int DW  = COL * BW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_rows = '0;
   logic          ofifo_valid;
   logic          ofifo_full = 1'b0;
   logic [DW-1:0] ofifo_out = '0;
   logic          ofifo_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          busy;
   logic          done;
   logic          overflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ofifo_drain_ctrl #(.col(COL), .bw(BW), .aw(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
      .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done),
      .overflow(overflow)
   );

   // ofifo model: rd is registered, the row stays visible during the rd_en cycle
   // and is popped at the end of it.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_rows[$];
   logic valid_en = 1'b0;
   logic rd_en = 1'b0;
   logic rd_s;
   int   fcnt = 0;

   assign ofifo_valid = valid_en && (fcnt != 0);

   always begin
      @(posedge clk);
      rd_s = ofifo_rd;
      #1;
      if (rd_en && fq.size() > 0) void'(fq.pop_front());
      rd_en = rd_s;
      fcnt = fq.size();
      ofifo_out = (fcnt != 0) ? fq[0] : '0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_cyc[$];
   int wr_cyc[$];
   logic [AW-1:0] wr_addr[$];
   logic [DW-1:0] wr_data[$];
   int done_cyc[$];
   int busy_cnt = 0;
   int rd_bad = 0;

   always @(negedge clk) begin
      if (ofifo_rd === 1'b1) begin
         rd_cyc.push_back(cyc);
         if (!valid_en) rd_bad++;
      end
      if (mem_wr === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_din);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic clear_logs();
      rd_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      done_cyc.delete(); busy_cnt = 0; rd_bad = 0;
   endtask

   task automatic fill_rows(input int n, input bit fixed);
      exp_rows.delete();
      for (int i = 0; i < n; i++)
         exp_rows.push_back(fixed ? DW'(32'hA0 + i) : DW'($urandom));
   endtask

   // mode 0: valid always high, 1: valid low 5 cycles after 2nd write,
   // 2: random valid, 3: valid high with ofifo_full pulsed at s+3
   task automatic run_drain(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                            output int s, output bit timeout);
      int drop;
      bit dropped;
      drop = 0;
      dropped = 0;
      fq.delete();
      foreach (exp_rows[i]) fq.push_back(exp_rows[i]);
      valid_en = 1'b1;
      ofifo_full = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear_logs();
      start = 1'b1; base_addr = b; num_rows = n; s = cyc;
      timeout = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         base_addr = AW'($urandom);
         num_rows = AW1'($urandom);
         ofifo_full = (mode == 3) && (cyc == s + 3);
         if (mode == 1) begin
            if (!dropped && wr_cyc.size() == 2) begin dropped = 1; drop = 5; end
            valid_en = (drop == 0);
            if (drop > 0) drop--;
         end else if (mode == 2) begin
            valid_en = ($urandom_range(0, 9) < 7);
         end
         if (done_cyc.size() != 0) begin timeout = 1'b0; break; end
      end
      valid_en = 1'b1;
      ofifo_full = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      int active;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ofifo_rd, mem_wr, mem_addr, busy, done, overflow} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rd=%b wr=%b addr=%0d busy=%b done=%b ovf=%b, want all 0",
                  ofifo_rd, mem_wr, mem_addr, busy, done, overflow);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      fq.delete();
      for (int i = 0; i < 3; i++) fq.push_back(DW'($urandom));
      valid_en = 1'b1;
      active = 0;
      repeat (20) begin
         @(negedge clk);
         if (ofifo_rd !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) active++;
      end
      checks++;
      if (active !== 0) begin
         failures++;
         $display("FAIL idle_quiet: active cycles=%0d, want 0", active);
      end
      checks++;
      if (mem_addr !== '0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL idle_outputs: addr=%0d ovf=%b, want 0 0", mem_addr, overflow);
      end
      $display("test_reset: idle 20 cycles, active=%0d", active);
   endtask

   task automatic test_basic();
      int s; bit to; int consec;
      fill_rows(4, 1'b1);
      run_drain(AW'(16), AW1'(4), 0, s, to);
      checks++;
      if (to !== 1'b0 || done_cyc.size() !== 1) begin
         failures++;
         $display("FAIL basic_done_count: timeout=%0b done pulses=%0d, want 0 1", to, done_cyc.size());
      end
      checks++;
      if (wr_cyc.size() !== 4) begin
         failures++;
         $display("FAIL basic_wr_count: got %0d, want 4", wr_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== AW'(16 + i) || wr_data[i] !== exp_rows[i] || wr_cyc[i] !== s + 2 + 2 * i) begin
               failures++;
               $display("FAIL basic_wr%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                        i, wr_addr[i], wr_data[i], wr_cyc[i], 16 + i, exp_rows[i], s + 2 + 2 * i);
            end
         end
      end
      if (done_cyc.size() > 0) begin
         checks++;
         if (done_cyc[0] !== s + 9) begin
            failures++;
            $display("FAIL basic_done_cyc: got s+%0d, want s+9", done_cyc[0] - s);
         end
      end
      consec = 0;
      for (int i = 1; i < rd_cyc.size(); i++) if (rd_cyc[i] == rd_cyc[i-1] + 1) consec++;
      checks++;
      if (rd_cyc.size() !== 4 || consec !== 0) begin
         failures++;
         $display("FAIL basic_rd: pulses=%0d consecutive=%0d, want 4 0", rd_cyc.size(), consec);
      end
      checks++;
      if (busy_cnt !== 9) begin
         failures++;
         $display("FAIL basic_busy: busy cycles=%0d, want 9", busy_cnt);
      end
      checks++;
      if (mem_addr !== AW'(19) || mem_wr !== 1'b0) begin
         failures++;
         $display("FAIL basic_addr_hold: got addr=%0d wr=%b, want 19 0", mem_addr, mem_wr);
      end
      $display("test_basic: s=%0d writes=%0d reads=%0d", s, wr_cyc.size(), rd_cyc.size());
   endtask

   task automatic test_stall();
      int s; bit to;
      fill_rows(4, 1'b0);
      run_drain(AW'(16), AW1'(4), 1, s, to);
      checks++;
      if (to !== 1'b0 || done_cyc.size() !== 1 || rd_cyc.size() !== 4 || rd_bad !== 0) begin
         failures++;
         $display("FAIL stall_counts: timeout=%0b done=%0d rd=%0d rd_while_invalid=%0d, want 0 1 4 0",
                  to, done_cyc.size(), rd_cyc.size(), rd_bad);
      end
      checks++;
      if (wr_cyc.size() !== 4) begin
         failures++;
         $display("FAIL stall_wr_count: got %0d, want 4", wr_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== AW'(16 + i) || wr_data[i] !== exp_rows[i]) begin
               failures++;
               $display("FAIL stall_wr%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                        i, wr_addr[i], wr_data[i], 16 + i, exp_rows[i]);
            end
         end
         checks++;
         if (wr_cyc[2] !== wr_cyc[1] + 7) begin
            failures++;
            $display("FAIL stall_gap: 3rd write %0d cycles after 2nd, want 7", wr_cyc[2] - wr_cyc[1]);
         end
         if (done_cyc.size() > 0) begin
            checks++;
            if (done_cyc[0] !== wr_cyc[3] + 1) begin
               failures++;
               $display("FAIL stall_done: done at cyc %0d, want %0d", done_cyc[0], wr_cyc[3] + 1);
            end
         end
      end
      $display("test_stall: s=%0d writes=%0d reads=%0d", s, wr_cyc.size(), rd_cyc.size());
   endtask

   task automatic test_zero();
      int s; bit to;
      fill_rows(3, 1'b0);
      run_drain(AW'(100), AW1'(0), 0, s, to);
      checks++;
      if (to !== 1'b0 || done_cyc.size() !== 1 || (done_cyc.size() > 0 && done_cyc[0] !== s + 1)) begin
         failures++;
         $display("FAIL zero_done: timeout=%0b pulses=%0d, want done once at s+1", to, done_cyc.size());
      end
      checks++;
      if (wr_cyc.size() !== 0 || rd_cyc.size() !== 0 || busy_cnt !== 1) begin
         failures++;
         $display("FAIL zero_quiet: wr=%0d rd=%0d busy=%0d, want 0 0 1",
                  wr_cyc.size(), rd_cyc.size(), busy_cnt);
      end
      $display("test_zero: s=%0d done pulses=%0d", s, done_cyc.size());
   endtask

   task automatic test_wrap();
      int s; bit to;
      logic [AW-1:0] ea;
      fill_rows(4, 1'b0);
      run_drain(AW'(2046), AW1'(4), 0, s, to);
      checks++;
      if (to !== 1'b0 || wr_cyc.size() !== 4) begin
         failures++;
         $display("FAIL wrap_count: timeout=%0b writes=%0d, want 0 4", to, wr_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            ea = AW'((2046 + i) % (1 << AW));
            checks++;
            if (wr_addr[i] !== ea || wr_data[i] !== exp_rows[i]) begin
               failures++;
               $display("FAIL wrap_wr%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                        i, wr_addr[i], wr_data[i], ea, exp_rows[i]);
            end
         end
      end
      $display("test_wrap: s=%0d writes=%0d", s, wr_cyc.size());
   endtask

   task automatic test_random();
      int s; bit to; int n; int consec;
      logic [AW-1:0] b, ea;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 8);
         b = AW'($urandom);
         fill_rows(n, 1'b0);
         run_drain(b, AW1'(n), 2, s, to);
         consec = 0;
         for (int i = 1; i < rd_cyc.size(); i++) if (rd_cyc[i] == rd_cyc[i-1] + 1) consec++;
         checks++;
         if (to !== 1'b0 || done_cyc.size() !== 1 || rd_cyc.size() !== n || rd_bad !== 0 || consec !== 0) begin
            failures++;
            $display("FAIL rand%0d_counts: timeout=%0b done=%0d rd=%0d bad=%0d consec=%0d, want 0 1 %0d 0 0",
                     it, to, done_cyc.size(), rd_cyc.size(), rd_bad, consec, n);
         end
         checks++;
         if (wr_cyc.size() !== n) begin
            failures++;
            $display("FAIL rand%0d_wr_count: got %0d, want %0d", it, wr_cyc.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               ea = b + AW'(i);
               checks++;
               if (wr_addr[i] !== ea || wr_data[i] !== exp_rows[i]) begin
                  failures++;
                  $display("FAIL rand%0d_wr%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                           it, i, wr_addr[i], wr_data[i], ea, exp_rows[i]);
               end
            end
            if (done_cyc.size() > 0) begin
               checks++;
               if (done_cyc[0] !== wr_cyc[n-1] + 1) begin
                  failures++;
                  $display("FAIL rand%0d_done: done at %0d, want %0d", it, done_cyc[0], wr_cyc[n-1] + 1);
               end
            end
         end
         $display("test_random[%0d]: base=%0d n=%0d writes=%0d", it, b, n, wr_cyc.size());
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      fill_rows(4, 1'b0);
      fq.delete();
      foreach (exp_rows[i]) fq.push_back(exp_rows[i]);
      valid_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear_logs();
      start = 1'b1; base_addr = AW'(16); num_rows = AW1'(4);
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (rd_cyc.size() == 2) begin seen = 1'b1; break; end
      end
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_logs();
      repeat (10) begin @(posedge clk); #1; end
      checks++;
      if (seen !== 1'b1) begin
         failures++;
         $display("FAIL resetmid_second_rd: second read seen=%0b, want 1", seen);
      end
      checks++;
      if (wr_cyc.size() !== 0 || rd_cyc.size() !== 0 || busy_cnt !== 0 || done_cyc.size() !== 0) begin
         failures++;
         $display("FAIL resetmid_quiet: wr=%0d rd=%0d busy=%0d done=%0d, want all 0",
                  wr_cyc.size(), rd_cyc.size(), busy_cnt, done_cyc.size());
      end
      fq.delete();
      $display("test_reset_mid: reset at 2nd read, post-reset writes=%0d", wr_cyc.size());
   endtask

   task automatic test_overflow();
      int s; bit to; int low;
      fill_rows(4, 1'b0);
      run_drain(AW'(40), AW1'(4), 3, s, to);
      checks++;
      if (to !== 1'b0 || wr_cyc.size() !== 4 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: timeout=%0b writes=%0d overflow=%b, want 0 4 1", to, wr_cyc.size(), overflow);
      end
      low = 0;
      repeat (5) begin
         @(negedge clk);
         if (overflow !== 1'b1) low++;
      end
      checks++;
      if (low !== 0) begin
         failures++;
         $display("FAIL ovf_sticky: cycles low=%0d, want 0", low);
      end
      fill_rows(0, 1'b0);
      run_drain(AW'(0), AW1'(0), 0, s, to);
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %b after start, want 0", overflow);
      end
      $display("test_overflow: overflow after clearing start=%b", overflow);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_wrap();
      test_random();
      test_reset_mid();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ofifo_drain_ctrl.md
# ofifo_drain_ctrl

Sequencer that empties the output FIFO (`ofifo`, `col` lanes of `bw` bits) into the psum SRAM after a compute pass. On `start` it pops exactly `num_rows` full rows from the ofifo, one SRAM write per row, to consecutive addresses beginning at `base_addr`, then pulses `done`. It sits between the ofifo read side and the SRAM write port, and is the only driver of the ofifo `rd` input.

## Interface
- `col`, default 8: ofifo lanes; must match the ofifo instance.
- `bw`, default 4: bits per lane.
- `aw`, default 11: SRAM address width.
- `clk`  in  1  clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command; sampled only in IDLE.
- `base_addr`  in  aw  first SRAM address; captured when `start` is accepted.
- `num_rows`  in  aw+1  rows to drain; captured when `start` is accepted.
- `ofifo_valid`  in  1  ofifo `o_valid`: every lane holds at least one entry.
- `ofifo_full`  in  1  ofifo `o_full`.
- `ofifo_out`  in  col*bw  ofifo `out` data.
- `ofifo_rd`  out  1  read request to the ofifo `rd` input.
- `mem_wr`  out  1  SRAM write strobe, active-high.
- `mem_addr`  out  aw  SRAM write address.
- `mem_din`  out  col*bw  SRAM write data.
- `busy`  out  1  high in DRAIN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky error flag.

## Operation
- States:
  - IDLE -> DRAIN on `start` when `num_rows` != 0.
  - IDLE -> DONE on `start` when `num_rows` == 0.
  - DRAIN -> DONE when the row-`num_rows` write occurs.
  - DONE -> IDLE unconditionally after one cycle.
- `start` outside IDLE is ignored. The captured base and count do not change until the next accepted `start`.
- Counters: `issued` and `written`, each aw+1 bits. Both clear when `start` is accepted.
- Read request: `ofifo_rd` = DRAIN & `ofifo_valid` & !`pend` & (`issued` < `num_rows`).
  - `ofifo_rd` is combinational from state and `ofifo_valid`.
  - Each issued read increments `issued` and sets `pend`.
- Pacing: the ofifo registers `rd` internally, so a pop lands one cycle late and `ofifo_valid` is stale in that cycle. `pend` therefore blocks back-to-back reads, limiting the drain rate to at most one row per 2 cycles.
- Write: `pend` is registered, so `mem_wr` = `pend`.
  - `mem_din` = `ofifo_out` (combinational pass-through).
  - `mem_addr` = (`base_addr` + `written`) mod 2^aw.
  - Each write increments `written` and clears `pend`.
- `mem_addr` is held at its last value when `mem_wr` = 0.
- Overflow: `ofifo_full` sampled high in any state sets `overflow`. It clears only on reset or on an accepted `start`.
- Reset values: state IDLE, `pend`/`issued`/`written` = 0, `ofifo_rd` = 0, `mem_wr` = 0, `mem_addr` = 0, `busy` = 0, `done` = 0, `overflow` = 0.

## Timing
- Cycle numbering: `start` accepted at cycle s; state is DRAIN at s+1.
- The first `ofifo_rd` can occur at s+1 if `ofifo_valid` is high.
- For `ofifo_rd` at cycle t:
  - ofifo internal `rd_en` is high in t+1.
  - `ofifo_out` shows that row during t+1.
  - `mem_wr` = 1 in t+1 with the matching address.
  - The row is popped at the end of t+1.
- With `ofifo_valid` continuously high, reads fall at s+1, s+3, … and writes at s+2, s+4, …
- The last write occurs at s+2N; `done` = 1 at s+2N+1; IDLE from s+2N+2.
- `num_rows` = 0: `done` at s+1 with no `ofifo_rd` and no `mem_wr`.
- `ofifo_valid` low stalls reads indefinitely with no timeout. A write already pending still completes.
- No `ofifo_rd` is issued once `issued` = `num_rows`, even if `ofifo_valid` stays high.
- Address wrap: `base_addr` = 2^aw−1 writes 2^aw−1, then 0, 1, …
- Reset in any state, including during the `mem_wr` cycle, returns to IDLE the next cycle. No further `ofifo_rd` or `mem_wr` is produced; a partial drain is abandoned.

## Test plan
- Reset then idle: `ofifo_valid` = 1, no `start` -> `ofifo_rd` = 0 and `mem_wr` = 0 for 20 cycles; all outputs 0.
- `base_addr` = 16, `num_rows` = 4, `ofifo_valid` always 1, rows 0xA0..0xA3 -> writes at s+2/4/6/8 to 16..19 with matching data; `done` at s+9; exactly 4 `ofifo_rd` pulses, never on consecutive cycles.
- Same command but `ofifo_valid` dropped for 5 cycles after the 2nd write -> no `ofifo_rd` while low; remaining writes go to 18 and 19 after `ofifo_valid` returns; `done` once.
- `num_rows` = 0 -> `done` at s+1, `busy` high only in s+1, no `mem_wr`.
- `aw` = 4, `base_addr` = 14, `num_rows` = 4 -> addresses 14, 15, 0, 1.
- Reset asserted in the cycle of the 2nd `ofifo_rd`; separately, `ofifo_full` pulsed during DRAIN -> after reset, no `mem_wr` and state IDLE; in the `ofifo_full` run, `overflow` stays 1 until the next `start`.
